// File: rtl/d_pipe.sv
// Parametrised DEPTH-stage, WIDTH-bit delay line with per-stage valid,
// advance enable, synchronous flush, occupancy count and a selectable tap.
module d_pipe #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    localparam int unsigned TW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             flush,
    input  logic [WIDTH-1:0] d,
    input  logic             d_vld,
    output logic [WIDTH-1:0] q,
    output logic             q_vld,
    input  logic [TW-1:0]    tap_sel,
    output logic [WIDTH-1:0] tap_q,
    output logic             tap_vld,
    output logic [CW-1:0]    occ
);

    logic [WIDTH-1:0] r_stg [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic [CW-1:0]    r_occ;
    logic             w_clear;

    // Reset and flush have identical effect; both outrank the advance.
    assign w_clear = !clr || flush;

    always_ff @(posedge clk) begin
        if (w_clear) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_stg[i] <= RST_VAL;
                r_vld[i] <= 1'b0;
            end
            r_occ <= '0;
        end else if (en) begin
            r_stg[0] <= d;
            r_vld[0] <= d_vld;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                r_stg[i] <= r_stg[i-1];
                r_vld[i] <= r_vld[i-1];
            end
            // Entry in, entry out: stays within 0..DEPTH by construction.
            r_occ <= r_occ + CW'(d_vld) - CW'(r_vld[DEPTH-1]);
        end
    end

    assign q     = r_stg[DEPTH-1];
    assign q_vld = r_vld[DEPTH-1];
    assign occ   = r_occ;

    // Out-of-range selects fall through to the reset value, invalid.
    always_comb begin
        tap_q   = RST_VAL;
        tap_vld = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (tap_sel == TW'(i)) begin
                tap_q   = r_stg[i];
                tap_vld = r_vld[i];
            end
        end
    end

endmodule

// File: tb/tb_d_pipe.sv
// Self-checking bench for d_pipe: directed steps with a queue scoreboard of
// entries in flight, plus a DEPTH=3 instance for the out-of-range tap case.
module tb_d_pipe;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 4;
    localparam logic [7:0]  RV    = 8'hA5;

    logic       clk = 1'b0;
    logic       clr, en, flush, d_vld;
    logic [7:0] d;
    logic [1:0] tap_sel, tap_sel3;
    logic [7:0] q, tap_q, q3, tap_q3;
    logic       q_vld, tap_vld, q_vld3, tap_vld3;
    logic [2:0] occ;
    logic [1:0] occ3;

    int n_chk  = 0;
    int n_pass = 0;

    // Front = oldest entry = last stage; {valid, data}.
    logic [8:0] sb [$];

    always #5 clk = ~clk;

    d_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RST_VAL(RV)) u_dut (
        .clk(clk), .clr(clr), .en(en), .flush(flush), .d(d), .d_vld(d_vld),
        .q(q), .q_vld(q_vld), .tap_sel(tap_sel), .tap_q(tap_q),
        .tap_vld(tap_vld), .occ(occ)
    );

    d_pipe #(.WIDTH(WIDTH), .DEPTH(3), .RST_VAL(RV)) u_dut3 (
        .clk(clk), .clr(clr), .en(en), .flush(flush), .d(d), .d_vld(d_vld),
        .q(q3), .q_vld(q_vld3), .tap_sel(tap_sel3), .tap_q(tap_q3),
        .tap_vld(tap_vld3), .occ(occ3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic sb_reset();
        sb.delete();
        for (int i = 0; i < DEPTH; i++) sb.push_back({1'b0, RV});
    endtask

    // One clock edge; the scoreboard follows the inputs seen at that edge.
    task automatic step();
        logic       c_clr, c_en;
        logic [8:0] c_in;
        logic [8:0] gone;
        c_clr = !clr || flush;
        c_en  = en;
        c_in  = {d_vld, d};
        @(posedge clk);
        #1;
        if (c_clr) sb_reset();
        else if (c_en) begin
            sb.push_back(c_in);
            gone = sb.pop_front();
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        n = 0;
        for (int i = 0; i < DEPTH; i++) n += int'(sb[i][8]);
        chk({tag, ".q"},     32'(q),     32'(sb[0][7:0]));
        chk({tag, ".q_vld"}, 32'(q_vld), 32'(sb[0][8]));
        chk({tag, ".occ"},   32'(occ),   32'(n));
        for (int i = 0; i < DEPTH; i++) begin
            tap_sel = 2'(i);
            #1;
            chk($sformatf("%s.tap_q%0d", tag, i),   32'(tap_q),   32'(sb[DEPTH-1-i][7:0]));
            chk($sformatf("%s.tap_vld%0d", tag, i), 32'(tap_vld), 32'(sb[DEPTH-1-i][8]));
        end
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, ".q"},     32'(q),     32'(8'hA5));
        chk({tag, ".q_vld"}, 32'(q_vld), 32'(0));
        chk({tag, ".occ"},   32'(occ),   32'(0));
        for (int i = 0; i < DEPTH; i++) begin
            tap_sel = 2'(i);
            #1;
            chk($sformatf("%s.tap_q%0d", tag, i),   32'(tap_q),   32'(8'hA5));
            chk($sformatf("%s.tap_vld%0d", tag, i), 32'(tap_vld), 32'(0));
        end
    endtask

    initial begin
        logic [2:0] occ_exp [6];
        logic [7:0] q_exp   [6];
        logic [3:0] vpat;
        occ_exp = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4};
        q_exp   = '{8'hA5, 8'hA5, 8'hA5, 8'h01, 8'h02, 8'h03};
        vpat    = 4'b0101;
        tap_sel = '0; tap_sel3 = '0;
        sb_reset();

        // Reset with random inputs
        clr = 1'b0;
        for (int i = 0; i < 2; i++) begin
            en = 1'($urandom); flush = 1'($urandom);
            d = 8'($urandom); d_vld = 1'($urandom);
            step();
        end
        check_cleared("reset");
        check_all("reset_sb");

        // Streaming 01..06
        clr = 1'b1; flush = 1'b0; en = 1'b1; d_vld = 1'b1;
        for (int i = 0; i < 6; i++) begin
            d = 8'(i + 1);
            step();
            chk($sformatf("stream.occ%0d", i), 32'(occ), 32'(occ_exp[i]));
            chk($sformatf("stream.q%0d", i),   32'(q),   32'(q_exp[i]));
            if (i >= 3) chk($sformatf("stream.qv%0d", i), 32'(q_vld), 32'(1));
        end
        check_all("stream");

        // Stall: fill 10..13, hold three cycles, then resume
        for (int i = 0; i < 4; i++) begin d = 8'h10 + 8'(i); step(); end
        chk("stall.fill_q", 32'(q), 32'(8'h10));
        en = 1'b0; d = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("stall.q%0d", i),   32'(q),   32'(8'h10));
            chk($sformatf("stall.occ%0d", i), 32'(occ), 32'(4));
            check_all($sformatf("stall%0d", i));
        end
        en = 1'b1;
        d = 8'h14; step(); chk("resume.q0", 32'(q), 32'(8'h11));
        d = 8'h15; step(); chk("resume.q1", 32'(q), 32'(8'h12));

        // Bubbles: valid 1,0,1,0 with data 20..23
        for (int i = 0; i < 4; i++) begin
            d = 8'h20 + 8'(i); d_vld = vpat[i];
            step();
        end
        chk("bubble.occ", 32'(occ), 32'(2));
        d_vld = 1'b0; d = 8'h00;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("bubble.q%0d", i),  32'(q),     32'(8'h20 + 8'(i)));
            chk($sformatf("bubble.qv%0d", i), 32'(q_vld), 32'(vpat[i]));
            step();
        end
        check_all("bubble_end");

        // Flush wins over en with a full pipeline
        d_vld = 1'b1;
        for (int i = 0; i < 4; i++) begin d = 8'h40 + 8'(i); step(); end
        chk("flush.pre_occ", 32'(occ), 32'(4));
        flush = 1'b1; d = 8'h99; step();
        flush = 1'b0;
        check_cleared("flush");

        // Reset with full pipeline, en=1, flush=0
        for (int i = 0; i < 4; i++) begin d = 8'h50 + 8'(i); step(); end
        chk("rst.pre_qv", 32'(q_vld), 32'(1));
        clr = 1'b0; d = 8'h77; step();
        clr = 1'b1;
        check_cleared("rst_full");

        // Tap sweep with stages 30..33; DEPTH=3 out-of-range tap
        for (int i = 0; i < 4; i++) begin d = 8'h30 + 8'(i); step(); end
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tap_sel = 2'(i);
            #1;
            chk($sformatf("tap.q%0d", i), 32'(tap_q),   32'(8'h33 - 8'(i)));
            chk($sformatf("tap.v%0d", i), 32'(tap_vld), 32'(1));
        end
        tap_sel3 = 2'd3; #1;
        chk("tap3.oor_q", 32'(tap_q3),   32'(8'hA5));
        chk("tap3.oor_v", 32'(tap_vld3), 32'(0));
        tap_sel3 = 2'd0; #1;
        chk("tap3.q0", 32'(tap_q3), 32'(8'h33));
        chk("tap3.q",  32'(q3),     32'(8'h31));
        chk("tap3.occ", 32'(occ3),  32'(3));

        // Random traffic against the scoreboard
        for (int i = 0; i < 40; i++) begin
            en = 1'($urandom); d = 8'($urandom); d_vld = 1'($urandom);
            flush = ($urandom_range(0, 15) == 0);
            step();
            check_all($sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/d_pipe.md
# d_pipe

Parametrised multi-stage register pipeline: a `WIDTH`-bit, `DEPTH`-stage delay line of D flip-flops with per-stage valid tracking, a global advance enable, synchronous flush, and a selectable tap output. It generalises the single-bit clear-able flip-flop into the standard delay and retiming element for datapaths. Typical uses are aligning operands across pipelined units and delaying control alongside data.

## Interface

Parameters:
- `WIDTH`, 8: data width in bits, ≥1.
- `DEPTH`, 4: number of register stages, ≥1.
- `RST_VAL`, 0: `WIDTH`-bit value loaded into every data stage on reset and on flush.

Ports (`TW` = max(1, $clog2(DEPTH)); `CW` = $clog2(DEPTH+1)):
- `clk`  in  1  clock; all state updates on the rising edge.
- `clr`  in  1  reset; **synchronous, active-low** (`clr`=0 resets on the next rising edge of `clk`).
- `en`  in  1  advance: when 1, every stage shifts by one position.
- `flush`  in  1  synchronous clear of all stages (data and valid).
- `d`  in  WIDTH  input data.
- `d_vld`  in  1  input valid, captured with `d`.
- `q`  out  WIDTH  last-stage data, stage[DEPTH-1].
- `q_vld`  out  1  last-stage valid.
- `tap_sel`  in  TW  stage index for the tap output.
- `tap_q`  out  WIDTH  data of stage[`tap_sel`].
- `tap_vld`  out  1  valid of stage[`tap_sel`].
- `occ`  out  CW  count of stages currently holding valid = 1.

## Operation

- **State:** `DEPTH` data registers `stg[0..DEPTH-1]`, `DEPTH` valid bits `vld[0..DEPTH-1]`, and the `occ` register.
- **Per-edge priority, highest first:**
  - `clr`=0: all `stg` ← `RST_VAL`, all `vld` ← 0, `occ` ← 0.
  - `flush`=1: same effect as reset; takes precedence over `en`.
  - `en`=1: `stg[0]` ← `d`, `vld[0]` ← `d_vld`, and `stg[i]` ← `stg[i-1]`, `vld[i]` ← `vld[i-1]` for i=1..DEPTH-1.
  - Otherwise: all state holds.
- **Data and valid are independent.** Data shifts regardless of `d_vld`. An entry with valid = 0 still carries its data, and `q` shows it.
- **`occ` update:** `occ` is registered and equals the popcount of the `vld` vector that results from the same edge.
  - When shifting: `occ` ← `occ` + `d_vld` − `vld[DEPTH-1]`.
  - Range is 0..DEPTH and it never wraps.
- **Outputs:**
  - `q` and `q_vld` come directly from the last stage's registers.
  - `tap_q` and `tap_vld` are a combinational mux on `tap_sel`.
  - For `tap_sel` ≥ `DEPTH`: `tap_q` = `RST_VAL` and `tap_vld` = 0.
- **DEPTH=1:** a single enabled register. `tap_sel` is 1 bit, and only value 0 is in range.

## Timing

- **Reset values:**
  - `q` = `RST_VAL`, `q_vld` = 0, `occ` = 0.
  - `tap_q` = `RST_VAL` and `tap_vld` = 0 for any `tap_sel`.
- **Latency:** a sample presented at edge k with `en`=1 appears on `q` after edge k+DEPTH−1, provided `en`=1 on every one of those edges. In other words, it is captured into `stg[0]` at edge k and reaches `stg[DEPTH-1]` DEPTH−1 edges later.
- **Stalls:** any cycle with `en`=0 extends latency by one cycle and loses no data. There is no internal back-pressure. Output consumption is the caller's responsibility.
- **Tap path:** `tap_q` and `tap_vld` have zero-cycle latency from `tap_sel`. This is a combinational path.
- **Simultaneous events:**
  - `flush` together with `en`: flush wins, and the input sample is discarded.
  - Reset while the pipeline is full: all stages are cleared on that edge, and `q_vld` is 0 from the following cycle.
- **Throughput:** one sample per cycle while `en`=1.

## Test plan

Configuration: `WIDTH`=8, `DEPTH`=4, `RST_VAL`=8'hA5.

1. **Reset:** hold `clr`=0 for 2 edges with random inputs → `q`=8'hA5, `q_vld`=0, `occ`=0; `tap_q`=8'hA5 for `tap_sel`=0..3.
2. **Streaming:** `en`=1, `d_vld`=1, `d`=8'h01,02,03,04,05 on consecutive edges → `q` shows 8'h01 (with `q_vld`=1) after the 4th edge, then 02 and 03 on following cycles; `occ` reads 1,2,3,4,4.
3. **Stall:** fill the pipeline with 8'h10..13, then `en`=0 for 3 cycles with `d`=8'hFF → `q`, `occ` and all taps are unchanged. When `en` returns to 1, the order resumes as 8'h11, 8'h12, and so on.
4. **Bubbles:** `en`=1 with `d_vld` pattern 1,0,1,0 and `d`=8'h20..23 → `q_vld` sequence is 1,0,1,0 with data 8'h20..23 intact; `occ` settles at 2.
5. **Flush and reset priority:**
   - Pipeline full with `occ`=4; assert `flush`=1 and `en`=1 on one edge → all stages read 8'hA5/0 and `occ`=0.
   - Separately, assert `clr`=0 together with `flush`=0 and `en`=1 → same reset result.
6. **Tap bounds:** with stages holding 8'h30..33, sweep `tap_sel`=0..3 → `tap_q`=8'h33,32,31,30 (stage 0 holds the newest sample). Because `tap_sel` is only 2 bits at `DEPTH`=4, the out-of-range case (`tap_q`=8'hA5, `tap_vld`=0) is covered at `DEPTH`=3 with `tap_sel`=3.
